// File: rtl/sign_mag_pwm_if.sv
// sign_mag_pwm_if: groups the run/duty/direction request and the two-leg PWM
// outputs of sign_mag_pwm into one bundle.
//   en            run enable (low forces idle)
//   pwm_data      requested duty magnitude, 0..2**Width-1
//   sign          requested direction, 1 selects out_a, 0 selects out_b
//   out_a/out_b   PWM legs
//   dir           currently applied direction
//   period_start  one-cycle pulse on the first cycle of each run period
//   dead          high while both legs are held off for a reversal
// master: the requester (upstream stage / bench). slave: the PWM block.
interface sign_mag_pwm_if #(
  parameter int unsigned Width = 3
);
  logic             en;
  logic [Width-1:0] pwm_data;
  logic             sign;
  logic             out_a;
  logic             out_b;
  logic             dir;
  logic             period_start;
  logic             dead;

  modport master (
    output en,
    output pwm_data,
    output sign,
    input  out_a,
    input  out_b,
    input  dir,
    input  period_start,
    input  dead
  );

  modport slave (
    input  en,
    input  pwm_data,
    input  sign,
    output out_a,
    output out_b,
    output dir,
    output period_start,
    output dead
  );
endinterface

// File: rtl/sign_mag_pwm.sv
// sign_mag_pwm: sign-magnitude PWM generator with double-buffered duty and
// direction and a dead interval on every direction reversal.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sign_mag_pwm_if slave: en, pwm_data, sign in; out_a, out_b, dir,
//          period_start, dead out
// A period is P = 2**Width-1 clocks (cnt 0..P-1). Duty and sign are sampled
// only on the last cycle of a period, so mid-period input changes never
// disturb the waveform in flight. All outputs decode from registers only.
module sign_mag_pwm #(
  parameter int unsigned Width    = 3,
  parameter int unsigned DeadTime = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sign_mag_pwm_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  localparam int unsigned DcW = (DeadTime > 1) ? $clog2(DeadTime) : 1;

  // Last count of a period is P-1 = 2**Width-2.
  localparam logic [Width-1:0] CntLast  = Width'((2 ** Width) - 2);
  localparam logic [DcW-1:0]   DeadLast = DcW'((DeadTime > 0) ? DeadTime - 1 : 0);

  state_e           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] duty_q, duty_d;
  logic             dir_q, dir_d;
  logic             next_sign_q, next_sign_d;
  logic [DcW-1:0]   dead_cnt_q, dead_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      next_sign_q <= 1'b0;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      next_sign_q <= next_sign_d;
      dead_cnt_q  <= dead_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    next_sign_d = next_sign_q;
    dead_cnt_d  = dead_cnt_q;

    if (!bus.en) begin
      // Abort from any state; duty and direction are kept for visibility.
      state_d    = StIdle;
      cnt_d      = '0;
      dead_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Legs are already off, so a start never needs a dead interval.
          duty_d  = bus.pwm_data;
          dir_d   = bus.sign;
          cnt_d   = '0;
          state_d = StRun;
        end
        StRun: begin
          if (cnt_q == CntLast) begin
            duty_d      = bus.pwm_data;
            next_sign_d = bus.sign;
            if (bus.sign == dir_q) begin
              cnt_d = '0;
            end else if (DeadTime > 0) begin
              state_d    = StDead;
              dead_cnt_d = '0;
            end else begin
              dir_d = bus.sign;
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + Width'(1);
          end
        end
        StDead: begin
          dead_cnt_d = dead_cnt_q + DcW'(1);
          if (dead_cnt_q == DeadLast) begin
            dir_d   = next_sign_q;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Duty equal to P keeps cnt < duty true on every count, so the active leg
  // stays high across period boundaries with no gap.
  logic in_run;
  logic leg_on;

  always_comb begin
    in_run           = (state_q == StRun);
    leg_on           = in_run && (cnt_q < duty_q);
    bus.out_a        = leg_on && dir_q;
    bus.out_b        = leg_on && !dir_q;
    bus.period_start = in_run && (cnt_q == '0);
    bus.dead         = (state_q == StDead);
    bus.dir          = dir_q;
  end

  legs_exclusive_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.out_a && bus.out_b));

endmodule

// File: tb/tb_sign_mag_pwm.sv
// Bench for sign_mag_pwm: a period-level behavioural model checked every
// cycle, directed scenarios pinned with literal waveform counts, then random
// enable/duty/sign/reset traffic.
module tb_sign_mag_pwm;
  localparam int unsigned Width    = 3;
  localparam int unsigned DeadTime = 2;
  localparam int          P        = (1 << Width) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sign_mag_pwm_if #(.Width(Width)) bus ();

  sign_mag_pwm #(
    .Width    (Width),
    .DeadTime (DeadTime)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: running flag, position within the period, remaining dead cycles.
  bit m_on   = 1'b0;
  int m_gap  = 0;
  int m_pos  = 0;
  int m_duty = 0;
  bit m_dir  = 1'b0;
  bit m_pend = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_on = 1'b0; m_gap = 0; m_pos = 0; m_duty = 0; m_dir = 1'b0; m_pend = 1'b0;
      end else if (!bus.en) begin
        m_on = 1'b0; m_gap = 0; m_pos = 0;
      end else if (!m_on) begin
        m_on   = 1'b1;
        m_duty = int'(bus.pwm_data);
        m_dir  = bus.sign;
        m_pos  = 0;
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
        if (m_gap == 0) begin
          m_dir = m_pend;
          m_pos = 0;
        end
      end else if (m_pos == P - 1) begin
        m_duty = int'(bus.pwm_data);
        m_pend = bus.sign;
        m_pos  = 0;
        if (bus.sign != m_dir) begin
          if (DeadTime > 0) m_gap = DeadTime;
          else m_dir = bus.sign;
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  logic exp_a, exp_b, exp_ps, exp_dead, exp_dir;
  assign exp_a    = m_on && (m_gap == 0) && (m_pos < m_duty) && m_dir;
  assign exp_b    = m_on && (m_gap == 0) && (m_pos < m_duty) && !m_dir;
  assign exp_ps   = m_on && (m_gap == 0) && (m_pos == 0);
  assign exp_dead = (m_gap > 0);
  assign exp_dir  = m_dir;

  initial begin
    forever begin
      @(negedge clk);
      vectors = vectors + 1;
      if (bus.out_a !== exp_a || bus.out_b !== exp_b || bus.period_start !== exp_ps ||
          bus.dead !== exp_dead || bus.dir !== exp_dir) begin
        miscompares = miscompares + 1;
        $display("FAIL cycle t=%0t got a=%b b=%b ps=%b dead=%b dir=%b exp a=%b b=%b ps=%b dead=%b dir=%b",
                 $time, bus.out_a, bus.out_b, bus.period_start, bus.dead, bus.dir,
                 exp_a, exp_b, exp_ps, exp_dead, exp_dir);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors = vectors + 1;
    if (got != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Sample n consecutive cycles and compare high-cycle counts per output.
  task automatic seg(input string name, input int n, input int ea, input int eb,
                     input int eps, input int ed);
    int na = 0, nb = 0, nps = 0, nd = 0;
    repeat (n) begin
      @(negedge clk);
      na  += int'(bus.out_a);
      nb  += int'(bus.out_b);
      nps += int'(bus.period_start);
      nd  += int'(bus.dead);
    end
    chk({name, ".a"}, na, ea);
    chk({name, ".b"}, nb, eb);
    chk({name, ".ps"}, nps, eps);
    chk({name, ".dead"}, nd, ed);
  endtask

  initial begin
    bus.en = 1'b1; bus.pwm_data = 3'd5; bus.sign = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.a", int'(bus.out_a), 0);
    chk("rst.b", int'(bus.out_b), 0);
    chk("rst.ps", int'(bus.period_start), 0);
    chk("rst.dead", int'(bus.dead), 0);
    chk("rst.dir", int'(bus.dir), 0);

    @(posedge clk); #2;
    rst_n = 1'b1; bus.pwm_data = 3'd3;
    @(posedge clk);  // first RUN edge
    seg("steady", 14, 6, 0, 2, 0);

    bus.pwm_data = 3'd0;
    seg("duty0", 14, 0, 0, 2, 0);

    bus.pwm_data = 3'd7; bus.sign = 1'b0;
    seg("rev_to_b", 2, 0, 0, 0, 2);
    seg("full_b", 21, 0, 21, 3, 0);

    bus.pwm_data = 3'd3;
    seg("buf_cur", 3, 0, 3, 1, 0);
    bus.pwm_data = 3'd5;
    seg("buf_tail", 4, 0, 0, 0, 0);
    seg("buf_next", 7, 0, 5, 1, 0);

    bus.pwm_data = 3'd4; bus.sign = 1'b1;
    seg("rev_to_a", 2, 0, 0, 0, 2);
    seg("a4", 7, 4, 0, 1, 0);
    seg("mid_head", 3, 3, 0, 1, 0);
    bus.sign = 1'b0;
    seg("mid_tail", 4, 1, 0, 0, 0);
    chk("dir_before", int'(bus.dir), 1);
    seg("dead2", 2, 0, 0, 0, 2);
    chk("dir_in_dead", int'(bus.dir), 1);
    seg("b4", 7, 0, 4, 1, 0);
    chk("dir_after", int'(bus.dir), 0);

    seg("abort_head", 2, 0, 2, 1, 0);
    bus.en = 1'b0;
    seg("abort_idle", 3, 0, 0, 0, 0);

    bus.en = 1'b1;
    seg("restart", 7, 0, 4, 1, 0);
    bus.sign = 1'b1;
    seg("enter_dead", 1, 0, 0, 0, 1);
    @(posedge clk); #2;
    chk("pre_rst_dead", int'(bus.dead), 1);
    rst_n = 1'b0; bus.en = 1'b0;
    #1;
    chk("async.a", int'(bus.out_a), 0);
    chk("async.b", int'(bus.out_b), 0);
    chk("async.ps", int'(bus.period_start), 0);
    chk("async.dead", int'(bus.dead), 0);
    chk("async.dir", int'(bus.dir), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seg("post_rst_idle", 4, 0, 0, 0, 0);
    bus.en = 1'b1; bus.sign = 1'b1; bus.pwm_data = 3'd3;
    seg("rerun", 7, 3, 0, 1, 0);

    repeat (3000) begin
      @(negedge clk);
      bus.en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 3) == 0) bus.pwm_data = Width'($urandom_range(0, P));
      if ($urandom_range(0, 9) == 0) bus.sign = ~bus.sign;
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
